// File: rtl/fifo_packer.sv
// fifo_packer: packs RATIO narrow FIFO words into one registered wide beat with a lane mask and flush support
module fifo_packer #(
    parameter int SIZE      = 4,
    parameter int RATIO_IDX = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [SIZE-1:0]               in_data,
    input  logic                          flush,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [SIZE*(1<<RATIO_IDX)-1:0] out_data,
    output logic [(1<<RATIO_IDX)-1:0]     out_mask
);
    localparam int RATIO = 1 << RATIO_IDX;
    localparam logic [RATIO_IDX-1:0] LAST = RATIO_IDX'(RATIO - 1);
    logic [(RATIO-1)*SIZE-1:0] r_acc;
    logic [RATIO_IDX-1:0]      r_cnt;
    logic [SIZE*RATIO-1:0]     r_out_data;
    logic [RATIO-1:0]          r_out_mask;
    logic                      r_out_val;
    logic                      r_flush_pend;
    logic                      w_slot_free;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_load_full;
    logic                      w_flush_srv;
    logic                      w_flush_emit;
    logic [RATIO-1:0]          w_part_mask;
    always_comb begin
        w_slot_free  = !r_out_val || out_rdy;
        w_last       = r_cnt == LAST;
        in_rdy       = !rst && !r_flush_pend && (!w_last || w_slot_free);
        w_accept     = in_val && in_rdy;
        w_load_full  = w_accept && w_last;
        w_flush_srv  = r_flush_pend && w_slot_free;
        w_flush_emit = w_flush_srv && r_cnt != '0;
        w_part_mask  = ~({RATIO{1'b1}} << r_cnt);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_data   <= '0;
            r_out_mask   <= '0;
            r_out_val    <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= r_flush_pend ? !w_flush_srv : flush;
            r_out_val    <= (w_load_full || w_flush_emit) ? 1'b1 : (out_rdy ? 1'b0 : r_out_val);
            if (w_load_full) begin
                r_out_data <= {in_data, r_acc};
                r_out_mask <= '1;
                r_cnt      <= '0;
                r_acc      <= '0;
            end else if (w_flush_emit) begin
                r_out_data <= {{SIZE{1'b0}}, r_acc};
                r_out_mask <= w_part_mask;
                r_cnt      <= '0;
                r_acc      <= '0;
            end else if (w_accept) begin
                r_acc[r_cnt*SIZE +: SIZE] <= in_data;
                r_cnt                     <= r_cnt + 1'b1;
            end
        end
    end
    assign out_val  = r_out_val;
    assign out_data = r_out_data;
    assign out_mask = r_out_mask;
endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer: vector table, directed corner sequences and random traffic against a queue-based model
module tb_fifo_packer;
    logic        clk = 1'b0;
    logic        rst, in_val, flush, out_rdy;
    logic [3:0]  in_data;
    logic        in_rdy, out_val;
    logic [15:0] out_data;
    logic [3:0]  out_mask;
    int          checks = 0;
    int          failures = 0;
    int unsigned mq[$];
    logic        m_val = 1'b0;
    logic        m_fp = 1'b0;
    logic        m_rdy;
    logic [15:0] m_data = '0;
    logic [3:0]  m_mask = '0;
    typedef struct {
        logic r, v;
        logic [3:0] d;
        logic f, o, rdy, ov;
        logic [15:0] od;
        logic [3:0] om;
    } vec_t;
    vec_t tbl[16];
    fifo_packer #(.SIZE(4), .RATIO_IDX(2)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .flush(flush), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_mask(out_mask)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic f, input logic o);
        rst = r; in_val = v; in_data = d; flush = f; out_rdy = o;
    endtask
    task automatic pack();
        m_data = '0;
        foreach (mq[i]) m_data = m_data | (16'(mq[i]) << (4 * i));
        m_mask = 4'((1 << mq.size()) - 1);
    endtask
    task automatic tick();
        logic free, nb;
        #1;
        m_rdy = !rst && !m_fp && (mq.size() != 3 || !m_val || out_rdy);
        chk("in_rdy", in_rdy, m_rdy);
        chk("out_val", out_val, m_val);
        if (m_val) begin
            chk("out_data", out_data, m_data);
            chk("out_mask", out_mask, m_mask);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_val = 0; m_fp = 0; m_data = '0; m_mask = '0;
        end else begin
            free = !m_val || out_rdy;
            nb = 0;
            if (m_fp && free) begin
                if (mq.size() > 0) begin pack(); nb = 1; mq.delete(); end
                m_fp = 0;
            end else if (!m_fp && flush) m_fp = 1;
            if (in_val && m_rdy) begin
                mq.push_back(32'(in_data));
                if (mq.size() == 4) begin pack(); nb = 1; mq.delete(); end
            end
            m_val = nb ? 1'b1 : (out_rdy ? 1'b0 : m_val);
        end
        @(negedge clk);
    endtask
    initial begin
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[2]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[3]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[4]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4321, 4'hF};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[7]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[8]  = '{1'b0, 1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00BA, 4'h3};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0};
        tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0};
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].o);
            #1;
            chk($sformatf("vec%0d_in_rdy", i), in_rdy, tbl[i].rdy);
            chk($sformatf("vec%0d_out_val", i), out_val, tbl[i].ov);
            if (tbl[i].ov || tbl[i].r) begin
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
                chk($sformatf("vec%0d_out_mask", i), out_mask, tbl[i].om);
            end
            tick();
        end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
            tick();
        end
        chk("bp_held_data", out_data, 16'h4321);
        chk("bp_held_val", out_val, 1'b1);
        drive(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        #1 chk("bp_drain_rdy", in_rdy, 1'b1);
        tick();
        chk("bp_next_beat", out_data, 16'h8765);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b0, 1'b1);
            tick();
            if (i == 3) chk("b2b_beat0", out_data, 16'h3210);
            if (i == 7) chk("b2b_beat1", out_data, 16'h7654);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 4'(i + 8), i == 4, 1'b1);
            tick();
        end
        chk("ff_full_mask", out_mask, 4'hF);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        #1 chk("ff_stall", in_rdy, 1'b0);
        tick();
        chk("ff_no_empty_beat", out_val, 1'b0);
        tick();
        chk("ff_still_idle", out_val, 1'b0);
        drive(1'b0, 1'b1, 4'h5, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b1, 4'h6, 1'b0, 1'b1); tick();
        drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
        #1 chk("rst_in_rdy", in_rdy, 1'b0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 4'(i), 1'b0, 1'b1);
            tick();
        end
        chk("rst_new_beat", out_data, 16'h4321);
        chk("rst_new_val", out_val, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 60) == 0, ($urandom % 4) != 0, 4'($urandom), ($urandom % 12) == 0,
                  ($urandom % 3) != 0);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
